// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: opcodes, FSM states and helpers.
package alu_share_ctrl_pkg;

  // Arithmetic_unit opcodes
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_NOT = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  // Result returned for a rejected divide by zero
  localparam logic [31:0] DIV0_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // A divide with a zero divisor is answered locally and never reaches the ALU
  function automatic logic is_div0(input logic [2:0] op, input logic [15:0] b);
    return (op == OP_DIV) && (b == '0);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr (cyclic).
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] rr_ptr;

  // Cyclic priority search starting at rr_ptr
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_oh  = '0;
    grant_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= N) idx = idx - N;
      if ((grant_oh == '0) && req[idx]) begin
        grant_oh[idx] = 1'b1;
        grant_idx     = IW'(idx);
      end
    end
  end

  // Pointer moves to the slot after the winner on each accepted grant
  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (advance)
      rr_ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one Arithmetic_unit between N_REQ requesters with round-robin
// arbitration and returns each result over a valid/ready response channel.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [3*N_REQ-1:0]  req_op,
  input  logic [16*N_REQ-1:0] req_a,
  input  logic [16*N_REQ-1:0] req_b,
  output logic [2:0]          alu_op,
  output logic [15:0]         alu_op1,
  output logic [15:0]         alu_op2,
  input  logic [31:0]         alu_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [31:0]         rsp_data,
  output logic                rsp_err,
  output logic                busy
);

  if ((N_REQ < 2) || (N_REQ > 8)) begin : g_bad_n_req
    $error("alu_share_ctrl: N_REQ must be in 2..8");
  end
  if (ID_W != $clog2(N_REQ)) begin : g_bad_id_w
    $error("alu_share_ctrl: ID_W must equal clog2(N_REQ)");
  end

  state_t            state;
  logic [N_REQ-1:0]  grant_oh;
  logic [ID_W-1:0]   grant_idx;
  logic              accept;
  logic [2:0]        sel_op;
  logic [15:0]       sel_a;
  logic [15:0]       sel_b;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (accept),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx)
  );

  assign req_ready = ((state == ST_IDLE) && !rst) ? grant_oh : '0;
  assign accept    = |req_ready;
  assign busy      = (state != ST_IDLE);

  // Select the granted requester's op and operands
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_oh[i]) begin
        sel_op = req_op[3*i +: 3];
        sel_a  = req_a[16*i +: 16];
        sel_b  = req_b[16*i +: 16];
      end
    end
  end

  // Controller FSM. The alu_* registers double as the operand latches: loaded
  // on the accept edge, they are stable through ISSUE and hold until the next
  // issued op, so a divide-by-zero simply leaves them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      alu_op    <= '0;
      alu_op1   <= '0;
      alu_op2   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rsp_id <= grant_idx;
            if (is_div0(sel_op, sel_b)) begin
              rsp_data  <= DIV0_DATA;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              alu_op  <= sel_op;
              alu_op1 <= sel_a;
              alu_op2 <= sel_b;
              state   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          rsp_data  <= alu_result;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
